hex_rate_ctrl: RTL and testbench

Run/pause controller for the single-digit hex counter display. It generates a divided count-enable tick from CLOCK_50 at one of four switch-selected rates and sequences a 4-bit digit counter through IDLE/RUN/PAUSE under start/stop/clear controls. It drives the 7-segment pattern for HEX0. It sits between the board switches/keys and the HEX0 output and replaces free-running gated-clock counters: everything runs on CLOCK_50, with tick used only as an enable.

---
 rtl/hex_ctrl_pkg.sv | 24 ++
 rtl/seg7_hex.sv | 34 +++
 rtl/hex_rate_ctrl.sv | 139 +++++++++++++
 tb/tb_hex_rate_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hex_ctrl_pkg.sv
// hex_ctrl_pkg
// Shared definitions for the HEX digit rate controller family:
//   - controller state codes (IDLE / RUN / PAUSE)
//   - speed switch codes
//   - default board-rate divider constants for a 50 MHz clock
package hex_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_PAUSE = 2'd2;

    localparam logic [1:0] SPD_R1   = 2'b00;  // tick every cycle
    localparam logic [1:0] SPD_DIV1 = 2'b01;
    localparam logic [1:0] SPD_DIV2 = 2'b10;
    localparam logic [1:0] SPD_DIV3 = 2'b11;

    localparam int DEF_DIV1  = 50_000_000;
    localparam int DEF_DIV2  = 100_000_000;
    localparam int DEF_DIV3  = 200_000_000;
    localparam int DEF_CNT_W = 28;

endpackage

// File: rtl/seg7_hex.sv
// seg7_hex
// Purely combinational hex-to-7-segment decoder, reusable for any HEX digit.
// Ports:
//   i_val   [3:0]  value 0..15
//   o_seg_n [6:0]  active-low segments {g,f,e,d,c,b,a}, glyphs 0-9, A, b, C, d, E, F
module seg7_hex (
    input  logic [3:0] i_val,
    output logic [6:0] o_seg_n
);

    // Glyph lookup table.
    always_comb begin
        case (i_val)
            4'h0:    o_seg_n = 7'b1000000;
            4'h1:    o_seg_n = 7'b1111001;
            4'h2:    o_seg_n = 7'b0100100;
            4'h3:    o_seg_n = 7'b0110000;
            4'h4:    o_seg_n = 7'b0011001;
            4'h5:    o_seg_n = 7'b0010010;
            4'h6:    o_seg_n = 7'b0000010;
            4'h7:    o_seg_n = 7'b1111000;
            4'h8:    o_seg_n = 7'b0000000;
            4'h9:    o_seg_n = 7'b0010000;
            4'hA:    o_seg_n = 7'b0001000;
            4'hB:    o_seg_n = 7'b0000011;
            4'hC:    o_seg_n = 7'b1000110;
            4'hD:    o_seg_n = 7'b0100001;
            4'hE:    o_seg_n = 7'b0000110;
            4'hF:    o_seg_n = 7'b0001110;
            default: o_seg_n = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/hex_rate_ctrl.sv
// hex_rate_ctrl
// Run/pause controller for a single hex digit. A down-counting divider
// produces a one-cycle count-enable tick at a switch-selected rate; the digit
// counter advances on each tick while in RUN. Everything is on CLOCK_50.
// Ports:
//   CLOCK_50        system clock
//   clear_b         asynchronous active-low reset
//   speed   [1:0]   rate select (00 = every cycle, 01/10/11 = DIV1/DIV2/DIV3)
//   start, stop     level run/resume and pause/idle requests
//   clr             synchronous digit clear (state kept)
//   tick            one-cycle pulse in the cycle digit shows its new value
//   digit   [3:0]   current count
//   running         high while in RUN
//   HEX0    [6:0]   active-low segments of digit
module hex_rate_ctrl
    import hex_ctrl_pkg::*;
#(
    parameter int DIV1  = DEF_DIV1,
    parameter int DIV2  = DEF_DIV2,
    parameter int DIV3  = DEF_DIV3,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic       CLOCK_50,
    input  logic       clear_b,
    input  logic [1:0] speed,
    input  logic       start,
    input  logic       stop,
    input  logic       clr,
    output logic       tick,
    output logic [3:0] digit,
    output logic       running,
    output logic [6:0] HEX0
);

    // Divider reload value R(s)-1. The active rate is carried only by what
    // was loaded into r_cnt, so a switch change cannot shorten a period.
    function automatic logic [CNT_W-1:0] reload_val(input logic [1:0] s);
        logic [CNT_W-1:0] v;
        case (s)
            SPD_R1:   v = '0;
            SPD_DIV1: v = CNT_W'(DIV1 - 1);
            SPD_DIV2: v = CNT_W'(DIV2 - 1);
            SPD_DIV3: v = CNT_W'(DIV3 - 1);
            default:  v = '0;
        endcase
        return v;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_digit;
    logic             r_tick;
    logic             r_running;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_digit_nxt;
    logic             w_tick_nxt;
    logic [CNT_W-1:0] w_reload;

    assign w_reload = reload_val(speed);

    // Next-state logic; priority is clr > stop > start > count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_digit_nxt = r_digit;
        w_tick_nxt  = 1'b0;
        if (clr) begin
            // State kept: RUN continues from a fresh period.
            w_digit_nxt = 4'd0;
            w_cnt_nxt   = w_reload;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Keep the divider preloaded so start begins a full period.
                    w_cnt_nxt = w_reload;
                    if (start && !stop) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // Freeze cnt and digit; a due tick is dropped.
                        w_state_nxt = ST_PAUSE;
                    end else if (r_cnt == '0) begin
                        w_tick_nxt  = 1'b1;
                        w_digit_nxt = r_digit + 4'd1;
                        w_cnt_nxt   = w_reload;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (start) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = w_reload;
                end
            endcase
        end
    end

    // State, divider, digit and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge clear_b) begin
        if (!clear_b) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_digit   <= 4'd0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_digit   <= w_digit_nxt;
            r_tick    <= w_tick_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    assign tick    = r_tick;
    assign digit   = r_digit;
    assign running = r_running;

    seg7_hex u_seg7 (
        .i_val   (r_digit),
        .o_seg_n (HEX0)
    );

endmodule

// File: tb/tb_hex_rate_ctrl.sv
// tb_hex_rate_ctrl
// Self-checking bench: a deadline-based behavioural model tracks the absolute
// edge number of the next tick; directed scenarios pin known values, then a
// randomized phase exercises all controls against the model.
module tb_hex_rate_ctrl;

    logic       CLOCK_50 = 1'b0;
    logic       clear_b  = 1'b0;
    logic [1:0] speed    = 2'b00;
    logic       start    = 1'b0;
    logic       stop     = 1'b0;
    logic       clr      = 1'b0;
    logic       tick;
    logic [3:0] digit;
    logic       running;
    logic [6:0] HEX0;

    always #10 CLOCK_50 = ~CLOCK_50;

    hex_rate_ctrl #(.DIV1(4), .DIV2(8), .DIV3(16), .CNT_W(28)) dut (
        .CLOCK_50 (CLOCK_50),
        .clear_b  (clear_b),
        .speed    (speed),
        .start    (start),
        .stop     (stop),
        .clr      (clr),
        .tick     (tick),
        .digit    (digit),
        .running  (running),
        .HEX0     (HEX0)
    );

    localparam logic [6:0] GLYPH [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_tests   = 0;
    int n_fail    = 0;
    int tick_seen = 0;

    // Model: mode 0 idle, 1 run, 2 pause. m_dl = edge number of next tick
    // while running; m_rem = edges left (cnt) while paused.
    int m_mode  = 0;
    int m_digit = 0;
    int m_tick  = 0;
    int m_dl    = 0;
    int m_rem   = 0;
    int m_n     = 0;

    function automatic int rate(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge CLOCK_50);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge CLOCK_50 or negedge clear_b);
            if (!clear_b) begin
                m_mode = 0; m_digit = 0; m_tick = 0;
            end else begin
                m_n++;
                if (clr) begin
                    m_digit = 0;
                    m_tick  = 0;
                    if (m_mode == 1) m_dl = m_n + rate(speed);
                    else if (m_mode == 2) m_rem = rate(speed) - 1;
                end else if (m_mode == 0) begin
                    m_tick = 0;
                    if (start && !stop) begin
                        m_mode = 1;
                        m_dl   = m_n + rate(speed);
                    end
                end else if (m_mode == 1) begin
                    if (stop) begin
                        m_tick = 0;
                        m_rem  = m_dl - m_n;
                        m_mode = 2;
                    end else if (m_n == m_dl) begin
                        m_tick  = 1;
                        m_digit = (m_digit + 1) % 16;
                        m_dl    = m_n + rate(speed);
                    end else begin
                        m_tick = 0;
                    end
                end else begin
                    m_tick = 0;
                    if (stop) begin
                        m_mode = 0;
                    end else if (start) begin
                        m_mode = 1;
                        m_dl   = m_n + m_rem + 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLOCK_50);
            chk("tick",    int'(tick),    m_tick);
            chk("digit",   int'(digit),   m_digit);
            chk("running", int'(running), (m_mode == 1) ? 1 : 0);
            chk("hex0",    int'(HEX0),    int'(GLYPH[m_digit]));
            if (tick) tick_seen++;
        end
    end

    initial begin
        int t0;
        cyc(2);
        chk("rst_digit", int'(digit), 0);
        chk("rst_hex0",  int'(HEX0), 7'h40);
        clear_b = 1'b1;
        cyc(2);

        // Base rate: ticks at e0+4, +8, +12.
        speed = 2'b01; start = 1'b1;
        cyc(1);
        start = 1'b0;
        t0 = tick_seen;
        cyc(12);
        chk("base_ticks", tick_seen - t0, 3);
        chk("base_digit", int'(digit), 3);
        chk("base_hex0",  int'(HEX0), 7'h30);
        stop = 1'b1; cyc(2); stop = 1'b0;
        clr = 1'b1; cyc(1); clr = 1'b0;

        // Full rate and wrap.
        speed = 2'b00; start = 1'b1;
        cyc(17);
        chk("wrap16_digit", int'(digit), 0);
        cyc(4);
        chk("wrap20_digit", int'(digit), 4);
        start = 1'b0;
        stop = 1'b1; cyc(2); stop = 1'b0;
        clr = 1'b1; cyc(1); clr = 1'b0;

        // Pause and resume.
        speed = 2'b10; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk("pause_running", int'(running), 0);
        t0 = tick_seen;
        cyc(10);
        chk("pause_ticks", tick_seen - t0, 0);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(12);
        stop = 1'b1; cyc(2); stop = 1'b0;
        chk("idle_running", int'(running), 0);

        // Rate change mid-period: 16-cycle period completes, then 4 apart.
        speed = 2'b11; start = 1'b1;
        cyc(1);
        start = 1'b0;
        t0 = tick_seen;
        cyc(4);
        speed = 2'b01;
        cyc(30);
        chk("rate_ticks", tick_seen - t0, 5);
        stop = 1'b1; cyc(2); stop = 1'b0;

        // start and stop together in IDLE.
        start = 1'b1; stop = 1'b1;
        cyc(3);
        start = 1'b0; stop = 1'b0;
        chk("startstop_running", int'(running), 0);

        // clr exactly when cnt==0 in RUN.
        clr = 1'b1; cyc(1); clr = 1'b0;
        speed = 2'b01; start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(7);
        clr = 1'b1; cyc(1); clr = 1'b0;
        chk("clr0_tick",  int'(tick), 0);
        chk("clr0_digit", int'(digit), 0);
        t0 = tick_seen;
        cyc(3);
        chk("clr0_gap", tick_seen - t0, 0);
        cyc(1);
        chk("clr0_next_tick",  int'(tick), 1);
        chk("clr0_next_digit", int'(digit), 1);

        // Async reset mid-RUN.
        speed = 2'b00;
        cyc(5);
        clear_b = 1'b0;
        #2;
        chk("arst_digit",   int'(digit), 0);
        chk("arst_tick",    int'(tick), 0);
        chk("arst_running", int'(running), 0);
        chk("arst_hex0",    int'(HEX0), 7'h40);
        cyc(2);
        clear_b = 1'b1;
        t0 = tick_seen;
        cyc(6);
        chk("arst_idle_ticks", tick_seen - t0, 0);

        // Randomized phase.
        for (int i = 0; i < 4000; i++) begin
            start   = ($urandom_range(0, 7) == 0);
            stop    = ($urandom_range(0, 15) == 0);
            clr     = ($urandom_range(0, 31) == 0);
            clear_b = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 19) == 0) speed = 2'($urandom_range(0, 3));
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
